// File: rtl/mdr_mem_if.sv
// Memory data register with sub-word load extraction, lane-aligned stores
// and a wait-state / timeout handshake toward the memory port.
module mdr_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15,
    localparam int LANES     = DATA_WIDTH / 8,
    localparam int OFFW      = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  MDRIn,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [OFFW-1:0]       addr_lo,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic [DATA_WIDTH-1:0] MDatain,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] BusMuxInMDR,
    output logic [DATA_WIDTH-1:0] MDataout,
    output logic [LANES-1:0]      byte_en,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] q, q_n;
    logic [DATA_WIDTH-1:0] dout_n, st_data, ld_shift, ld_ext;
    logic [LANES-1:0]      be_n, st_be;
    logic [1:0]            size_r, size_n;
    logic                  sx_r, sx_n;
    logic [OFFW-1:0]       off_r, off_n, st_off, ld_off;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  terr_n, done_n, tmo_hit;

    assign BusMuxInMDR = q;
    assign tmo_hit     = (TIMEOUT > 0) && (int'(cnt) == TIMEOUT - 1);

    // Store image is built from the live request inputs and captured on accept.
    always_comb begin
        st_off  = addr_lo & ~OFFW'(1);
        st_data = q;
        st_be   = '1;
        case (size)
            2'b00: begin
                for (int unsigned i = 0; i < LANES; i++) st_data[8*i +: 8] = q[7:0];
                st_be = LANES'(1) << addr_lo;
            end
            2'b01: begin
                for (int unsigned i = 0; i < LANES; i++) st_data[8*i +: 8] = q[8*(i%2) +: 8];
                st_be = LANES'(3) << st_off;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_off = '0;
        case (size_r)
            2'b00:   ld_off = off_r;
            2'b01:   ld_off = off_r & ~OFFW'(1);
            default: ;
        endcase
        ld_shift = MDatain >> {ld_off, 3'b000};
        ld_ext   = ld_shift;
        case (size_r)
            2'b00: begin
                ld_ext = DATA_WIDTH'(ld_shift[7:0]);
                if (sx_r && ld_shift[7]) ld_ext = ld_ext | ({DATA_WIDTH{1'b1}} << 8);
            end
            2'b01: begin
                ld_ext = DATA_WIDTH'(ld_shift[15:0]);
                if (sx_r && ld_shift[15]) ld_ext = ld_ext | ({DATA_WIDTH{1'b1}} << 16);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        dout_n  = MDataout;
        be_n    = byte_en;
        size_n  = size_r;
        sx_n    = sx_r;
        off_n   = off_r;
        cnt_n   = cnt;
        terr_n  = timeout_err;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (Read || Write) begin
                    size_n  = size;
                    sx_n    = sign_ext;
                    off_n   = addr_lo;
                    cnt_n   = '0;
                    terr_n  = 1'b0;
                    state_n = Read ? RD_WAIT : WR_WAIT;
                    if (!Read) begin
                        dout_n = st_data;
                        be_n   = st_be;
                    end
                end else if (MDRIn) begin
                    q_n = BusMuxOut;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ready) begin
                    if (state == RD_WAIT) q_n = ld_ext;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (tmo_hit) begin
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                if (state_n == IDLE) begin
                    dout_n = '0;
                    be_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            q           <= '0;
            MDataout    <= '0;
            byte_en     <= '0;
            size_r      <= '0;
            sx_r        <= 1'b0;
            off_r       <= '0;
            cnt         <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            q           <= q_n;
            MDataout    <= dout_n;
            byte_en     <= be_n;
            size_r      <= size_n;
            sx_r        <= sx_n;
            off_r       <= off_n;
            cnt         <= cnt_n;
            mem_rd      <= (state_n == RD_WAIT);
            mem_wr      <= (state_n == WR_WAIT);
            busy        <= (state_n != IDLE);
            done        <= done_n;
            timeout_err <= terr_n;
        end
    end
endmodule

// File: tb/tb_mdr_mem_if.sv
// Scoreboard bench for mdr_mem_if: driver pushes expected transactions,
// a negedge monitor compares strobes, store image, done timing and Q.
module tb_mdr_mem_if;
    logic        clock, clear, MDRIn, Read, Write, sign_ext, mem_ready;
    logic [1:0]  size, addr_lo;
    logic [31:0] BusMuxOut, MDatain, BusMuxInMDR, MDataout;
    logic [3:0]  byte_en;
    logic        mem_rd, mem_wr, busy, done, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] mq = '0;

    typedef struct {
        bit          wr;
        int          start;
        int          fin;
        logic [31:0] q;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;
    exp_t sb[$];

    mdr_mem_if #(.DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .clock(clock), .clear(clear), .MDRIn(MDRIn), .Read(Read), .Write(Write),
        .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo), .BusMuxOut(BusMuxOut),
        .MDatain(MDatain), .mem_ready(mem_ready), .BusMuxInMDR(BusMuxInMDR),
        .MDataout(MDataout), .byte_en(byte_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour expressed over a byte array of the memory word.
    function automatic logic [31:0] m_load(input logic [31:0] w, input int sz, input bit sx, input int off);
        int b[4];
        int v, base;
        for (int i = 0; i < 4; i++) b[i] = int'((w >> (8*i)) & 32'hFF);
        if (sz >= 2) return w;
        if (sz == 0) begin
            v = b[off];
            if (sx && v >= 128) v -= 256;
        end else begin
            base = (off / 2) * 2;
            v = b[base] + 256 * b[base+1];
            if (sx && v >= 32768) v -= 65536;
        end
        return v;
    endfunction

    task automatic m_store(input logic [31:0] qv, input int sz, input int off,
                           output logic [31:0] d, output logic [3:0] be);
        if (sz == 0) begin
            d  = (qv % 256) * 32'h01010101;
            be = 4'(1 << off);
        end else if (sz == 1) begin
            d  = (qv % 65536) * 32'h00010001;
            be = 4'(3 << ((off / 2) * 2));
        end else begin
            d  = qv;
            be = 4'hF;
        end
    endtask

    always @(negedge clock) begin
        if (!clear) begin
            if (sb.size() > 0 && cyc >= sb[0].start) begin
                if (cyc == sb[0].fin) begin
                    chk("done_pulse", done, 1);
                    chk("busy_end", busy, 0);
                    chk("q_after", BusMuxInMDR, sb[0].q);
                    void'(sb.pop_front());
                end else begin
                    chk("busy_wait", busy, 1);
                    chk("done_early", done, 0);
                    chk("mem_rd", mem_rd, !sb[0].wr);
                    chk("mem_wr", mem_wr, sb[0].wr);
                    if (sb[0].wr) begin
                        chk("st_data", MDataout, sb[0].data);
                        chk("st_be", byte_en, sb[0].be);
                    end
                end
            end else if (done) begin
                chk("unexpected_done", done, 0);
            end
        end
    end

    task automatic idle_inputs();
        Read = 0; Write = 0; MDRIn = 0; mem_ready = 0;
    endtask

    task automatic noise();
        Read = 1'($urandom); Write = 1'($urandom); MDRIn = 1'($urandom);
        BusMuxOut = $urandom; size = 2'($urandom); sign_ext = 1'($urandom);
        addr_lo = 2'($urandom);
    endtask

    task automatic bus_load(input logic [31:0] v);
        MDRIn = 1; BusMuxOut = v; mem_ready = 1'($urandom); MDatain = $urandom;
        @(posedge clock); #1;
        idle_inputs();
        mq = v;
        chk("bus_load", BusMuxInMDR, mq);
        chk("bus_no_rd", mem_rd, 0);
        chk("bus_no_wr", mem_wr, 0);
    endtask

    task automatic do_read(input logic [31:0] w, input int sz, input bit sx, input int off,
                           input int k, input bit all, input bit nz);
        exp_t e;
        Read = 1; size = 2'(sz); sign_ext = sx; addr_lo = 2'(off);
        if (all) begin Write = 1; MDRIn = 1; BusMuxOut = $urandom; end
        mq = m_load(w, sz, sx, off);
        e = '{wr: 0, start: cyc + 1, fin: cyc + 1 + k, q: mq, data: '0, be: '0};
        sb.push_back(e);
        @(posedge clock); #1;
        idle_inputs();
        for (int j = 1; j <= k; j++) begin
            if (nz) noise();
            mem_ready = (j == k);
            MDatain   = (j == k) ? w : $urandom;
            @(posedge clock); #1;
        end
        idle_inputs();
    endtask

    task automatic do_write(input int sz, input int off, input int k, input bit nz);
        exp_t e;
        logic [31:0] d;
        logic [3:0]  be;
        Write = 1; size = 2'(sz); addr_lo = 2'(off); sign_ext = 1'($urandom);
        if (nz) begin MDRIn = 1; BusMuxOut = $urandom; end
        m_store(mq, sz, off, d, be);
        e = '{wr: 1, start: cyc + 1, fin: cyc + 1 + k, q: mq, data: d, be: be};
        sb.push_back(e);
        @(posedge clock); #1;
        idle_inputs();
        for (int j = 1; j <= k; j++) begin
            if (nz) noise();
            mem_ready = (j == k);
            MDatain   = $urandom;
            @(posedge clock); #1;
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1; idle_inputs();
        size = 0; sign_ext = 0; addr_lo = 0; BusMuxOut = 0; MDatain = 0;
        #2;
        chk("rst_q", BusMuxInMDR, 0);
        chk("rst_dout", MDataout, 0);
        chk("rst_be", byte_en, 0);
        chk("rst_strobes", {mem_rd, mem_wr, busy, done, timeout_err}, 0);
        @(posedge clock); @(posedge clock); #1;
        clear = 0;

        bus_load(32'hDEADBEEF);
        do_read(32'h1280FF34, 0, 1, 2, 3, 0, 0);
        chk("signed_byte", BusMuxInMDR, 32'hFFFFFF80);
        do_read(32'h8001ABCD, 1, 0, 3, 2, 0, 0);
        chk("unsigned_half", BusMuxInMDR, 32'h00008001);
        do_read(32'h13579BDF, 2, 1, 1, 1, 0, 0);
        chk("word_load", BusMuxInMDR, 32'h13579BDF);

        bus_load(32'h000000A5);
        do_write(0, 1, 3, 0);
        bus_load(32'h0000BEEF);
        do_write(1, 2, 2, 0);

        // Timeout: mem_ready never rises.
        Read = 1; size = 2; mem_ready = 0;
        @(posedge clock); #1;
        idle_inputs();
        repeat (14) begin
            MDRIn = 1; BusMuxOut = $urandom;
            @(posedge clock); #1;
        end
        MDRIn = 0;
        chk("tmo_busy_e14", busy, 1);
        @(posedge clock); #1;
        chk("tmo_busy_drop", busy, 0);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_q_kept", BusMuxInMDR, mq);
        do_read(32'hCAFEF00D, 0, 0, 3, 1, 1, 0);
        chk("tmo_err_cleared", timeout_err, 0);
        chk("priority_read", BusMuxInMDR, 32'h000000CA);

        // Async clear in the middle of a read.
        Read = 1; size = 2;
        @(posedge clock); #1;
        idle_inputs();
        #2 clear = 1;
        #1;
        chk("clr_q", BusMuxInMDR, 0);
        chk("clr_outs", {mem_rd, mem_wr, busy, done, timeout_err, byte_en}, 0);
        chk("clr_dout", MDataout, 0);
        clear = 0;
        mq = 0;
        mem_ready = 1; MDatain = 32'h5A5A5A5A;
        @(posedge clock); #1;
        idle_inputs();
        chk("clr_ready_ignored", BusMuxInMDR, 0);
        chk("clr_no_busy", busy, 0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 2))
                0: bus_load($urandom);
                1: do_read($urandom, int'($urandom_range(0, 3)), 1'($urandom),
                           int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
                           1'($urandom), 1'($urandom));
                default: do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                  int'($urandom_range(1, 5)), 1'($urandom));
            endcase
        end

        repeat (3) @(posedge clock);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
